// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Purpose  : Serial line input and byte valid/ready handshake of uart_rx.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // master: the receiver producing bytes; slave: line driver and byte consumer
    modport master (
        input  rx,
        input  rx_ready,
        output data_out,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx,
        output rx_ready,
        input  data_out,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with internal oversample divider, mid-bit
//             sampling and valid/ready byte delivery with error pulses.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 2400,
    parameter int OVERSAMPLE = 16
) (
    input wire        clk,
    input wire        srst_n,
    uart_rx_if.master bus
);

    localparam int c_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OS_W  = $clog2(OVERSAMPLE);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0]  c_OS_MID   = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_OS_ONE   = c_OS_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;

    logic                r_rx_meta;
    logic                r_rx_s;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_OS_W-1:0]   r_os_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [2:0]          r_state;
    logic [7:0]          r_data_out;
    logic                r_rx_valid;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_os_tick;
    logic [2:0]          w_state_nxt;
    logic [c_OS_W-1:0]   w_os_nxt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_div_clr;
    logic                w_deliver;
    logic                w_frame_err;

    assign w_os_tick = (r_div_cnt == c_DIV_LAST);

    // Line synchroniser and free-running oversample divider
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_div_cnt <= '0;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
            if (w_div_clr || w_os_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state   <= S_IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_os_nxt    = r_os_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_div_clr   = 1'b0;
        w_deliver   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_os_nxt    = '0;
                    w_div_clr   = 1'b1;
                end
            end
            S_START: begin
                if (w_os_tick) begin
                    if (r_os_cnt == c_OS_MID) begin
                        // A start bit that is high again by mid-bit is a glitch
                        w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                        w_os_nxt    = '0;
                        w_bit_nxt   = '0;
                    end else begin
                        w_os_nxt = r_os_cnt + c_OS_ONE;
                    end
                end
            end
            S_DATA: begin
                if (w_os_tick) begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_os_nxt               = '0;
                        w_shift_nxt[r_bit_idx] = r_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_bit_nxt = r_bit_idx + 3'd1;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + c_OS_ONE;
                    end
                end
            end
            S_STOP: begin
                if (w_os_tick) begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_os_nxt = '0;
                        if (r_rx_s) begin
                            w_deliver   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state_nxt = S_WAIT_HI;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + c_OS_ONE;
                    end
                end
            end
            S_WAIT_HI: begin
                // A break must end before a new start edge can be recognised
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte delivery, handshake and error pulses
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_data_out  <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_deliver && r_rx_valid && !bus.rx_ready;
            if (w_deliver && (!r_rx_valid || bus.rx_ready)) begin
                r_data_out <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx at 160 clk per bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_BIT = 160;

    logic clk;
    logic srst_n;
    int   total;
    int   bad;

    // Activity observed one time unit after each rising edge
    int         cyc;
    int         n_rise;
    int         n_valid_hi;
    int         n_ferr;
    int         n_ovr;
    int         n_both;
    int         n_busy_rise;
    int         rise_cyc;
    logic [7:0] rise_data;
    logic       prev_valid;
    logic       prev_busy;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16)
    ) u_dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0; n_rise = 0; n_valid_hi = 0; n_ferr = 0; n_ovr = 0; n_both = 0;
        n_busy_rise = 0; rise_cyc = 0; rise_data = 8'h00; prev_valid = 1'b0; prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (bus.rx_valid && !prev_valid) begin
                n_rise    = n_rise + 1;
                rise_cyc  = cyc;
                rise_data = bus.data_out;
            end
            if (bus.rx_valid) n_valid_hi = n_valid_hi + 1;
            if (bus.frame_err) n_ferr = n_ferr + 1;
            if (bus.overrun) n_ovr = n_ovr + 1;
            if (bus.frame_err && bus.overrun) n_both = n_both + 1;
            if (bus.busy && !prev_busy) n_busy_rise = n_busy_rise + 1;
            prev_valid = bus.rx_valid;
            prev_busy  = bus.busy;
        end
    end

    // Called right after a falling edge; returns right after a falling edge
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            repeat (c_BIT) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        srst_n = 1'b0;
        bus.rx = 1'b1;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.data_out, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 000",
                     {bus.data_out, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy});
        end
        srst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_byte;
        int s_rise, s_hi, s_ferr, s_ovr, t0;
        @(negedge clk);
        bus.rx_ready = 1'b1;
        s_rise = n_rise; s_hi = n_valid_hi; s_ferr = n_ferr; s_ovr = n_ovr;
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (50) @(negedge clk);
        total++;
        if (n_rise - s_rise !== 1) begin
            bad++; $display("FAIL a5_valid_count: got %0d want 1", n_rise - s_rise);
        end
        total++;
        if (rise_data !== 8'hA5) begin
            bad++; $display("FAIL a5_data: got %h want a5", rise_data);
        end
        total++;
        if (rise_cyc - t0 < 1522 || rise_cyc - t0 > 1524) begin
            bad++; $display("FAIL a5_latency: got %0d want 1523", rise_cyc - t0);
        end
        total++;
        if (n_valid_hi - s_hi !== 1) begin
            bad++; $display("FAIL a5_valid_width: got %0d want 1", n_valid_hi - s_hi);
        end
        total++;
        if ((n_ferr - s_ferr) + (n_ovr - s_ovr) !== 0) begin
            bad++; $display("FAIL a5_flags: got %0d want 0", (n_ferr - s_ferr) + (n_ovr - s_ovr));
        end
    endtask

    task automatic test_glitch;
        int s_rise, s_ferr, s_busy;
        s_rise = n_rise; s_ferr = n_ferr; s_busy = n_busy_rise;
        bus.rx = 1'b0;
        repeat (30) @(negedge clk);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk);
        total++;
        if (n_busy_rise - s_busy !== 1) begin
            bad++; $display("FAIL glitch_busy_pulse: got %0d want 1", n_busy_rise - s_busy);
        end
        total++;
        if ((n_rise - s_rise) + (n_ferr - s_ferr) !== 0) begin
            bad++; $display("FAIL glitch_no_event: got %0d want 0", (n_rise - s_rise) + (n_ferr - s_ferr));
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL glitch_idle: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_framing;
        int s_rise, s_ferr;
        s_rise = n_rise; s_ferr = n_ferr;
        send_frame(8'h3C, 1'b0);
        repeat (500) @(negedge clk);
        total++;
        if (n_ferr - s_ferr !== 1) begin
            bad++; $display("FAIL ferr_pulse: got %0d want 1", n_ferr - s_ferr);
        end
        total++;
        if (n_rise - s_rise !== 0) begin
            bad++; $display("FAIL ferr_no_valid: got %0d want 0", n_rise - s_rise);
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL ferr_busy_low_line: got %b want 1", bus.busy);
        end
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL ferr_busy_released: got %b want 0", bus.busy);
        end
        s_rise = n_rise;
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        total++;
        if (n_rise - s_rise !== 1 || rise_data !== 8'h81) begin
            bad++; $display("FAIL after_ferr_byte: got %0d/%h want 1/81", n_rise - s_rise, rise_data);
        end
    endtask

    task automatic test_overrun;
        int s_ovr, s_ferr;
        bus.rx_ready = 1'b0;
        s_ovr = n_ovr; s_ferr = n_ferr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        total++;
        if (bus.data_out !== 8'h11 || bus.rx_valid !== 1'b1) begin
            bad++; $display("FAIL ovr_hold: got %h/%b want 11/1", bus.data_out, bus.rx_valid);
        end
        total++;
        if (n_ovr - s_ovr !== 1 || n_ferr - s_ferr !== 0) begin
            bad++; $display("FAIL ovr_pulse: got %0d/%0d want 1/0", n_ovr - s_ovr, n_ferr - s_ferr);
        end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        total++;
        if (bus.rx_valid !== 1'b0 || bus.data_out !== 8'h11) begin
            bad++; $display("FAIL ovr_accept: got %b/%h want 0/11", bus.rx_valid, bus.data_out);
        end
    endtask

    task automatic test_back_to_back;
        int s_ovr;
        bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        s_ovr = n_ovr;
        // The 0x22 stop bit is sampled on the 1523rd rising edge after its start edge
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (1522) @(negedge clk);
                total++;
                if (bus.data_out !== 8'h11 || bus.rx_valid !== 1'b1) begin
                    bad++; $display("FAIL b2b_pending: got %h/%b want 11/1", bus.data_out, bus.rx_valid);
                end
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
                total++;
                if (bus.data_out !== 8'h22 || bus.rx_valid !== 1'b1) begin
                    bad++; $display("FAIL b2b_replace: got %h/%b want 22/1", bus.data_out, bus.rx_valid);
                end
            end
        join
        total++;
        if (n_ovr - s_ovr !== 0) begin
            bad++; $display("FAIL b2b_no_overrun: got %0d want 0", n_ovr - s_ovr);
        end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int s_rise;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (c_BIT * 5 + 80) @(negedge clk);
                srst_n = 1'b0;
                @(negedge clk);
                total++;
                if ({bus.data_out, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
                    bad++;
                    $display("FAIL midreset_outputs: got %h want 000",
                             {bus.data_out, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy});
                end
                repeat (2) @(negedge clk);
                srst_n = 1'b1;
            end
        join
        s_rise = n_rise;
        repeat (100) @(negedge clk);
        total++;
        if (n_rise - s_rise !== 0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midreset_idle: got %0d/%b want 0/0", n_rise - s_rise, bus.busy);
        end
        bus.rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        total++;
        if (n_rise - s_rise !== 1 || rise_data !== 8'h5A) begin
            bad++; $display("FAIL midreset_next_byte: got %0d/%h want 1/5a", n_rise - s_rise, rise_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        srst_n = 1'b0;
        bus.rx = 1'b1;
        bus.rx_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        total++;
        if (n_both !== 0) begin
            bad++; $display("FAIL flags_exclusive: got %0d want 0", n_both);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
